// File: rtl/sprite_pixel_mixer.sv
// Per-pixel sprite compositor: reads enabled sprites in priority order through one shared
// memory port, stops at the first opaque colour, and hands the pixel downstream via valid/ready.
module sprite_pixel_mixer #(
  parameter int                N_SPRITES   = 8,
  parameter int                SEL_W       = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1,
  parameter int                ADDR_W      = 16,
  parameter int                PIXELS      = 2 ** ADDR_W,
  parameter int                DATA_W      = 24,
  parameter int                MEM_LAT     = 1,
  parameter logic [DATA_W-1:0] TRANSPARENT = 24'hFF00FF,
  parameter logic [DATA_W-1:0] BG_COLOR    = 24'h000000
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 ENABLE,
  input  logic [N_SPRITES-1:0] SPRITES_EN,
  input  logic [DATA_W-1:0]    DATA_IN,
  output logic                 MEM_RD,
  output logic [ADDR_W-1:0]    MEM_ADDR,
  output logic [SEL_W-1:0]     MEM_SEL,
  input  logic                 PIX_READY,
  output logic [DATA_W-1:0]    RGB,
  output logic                 RGB_VALID,
  output logic [SEL_W-1:0]     HIT_SEL,
  output logic                 HIT_BG,
  output logic                 FRAME_END,
  output logic                 BUSY
);

  localparam int                CNT_W     = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_OUT
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [N_SPRITES-1:0]  mask_q;
  logic [SEL_W-1:0]      sel_q;
  logic [SEL_W-1:0]      low_idx;
  logic [ADDR_W-1:0]     addr_q;
  logic [CNT_W-1:0]      wait_q;
  logic [DATA_W-1:0]     rgb_q;
  logic [SEL_W-1:0]      hit_sel_q;
  logic                  hit_bg_q;
  logic                  frame_end_q;
  logic                  opaque;
  logic                  last_pix;
  logic                  load_hit;
  logic                  load_bg;
  logic                  accept;

  // Lowest set bit wins: bit 0 is the highest-priority sprite.
  always_comb begin
    low_idx = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (mask_q[i]) low_idx = SEL_W'(i);
    end
  end

  assign opaque   = (DATA_IN != TRANSPARENT);
  assign last_pix = (addr_q == LAST_ADDR);
  assign accept   = (state_q == S_OUT) && PIX_READY;
  assign load_hit = (state_q == S_CAPTURE) && opaque;
  assign load_bg  = ((state_q == S_START) && (SPRITES_EN == '0)) ||
                    ((state_q == S_CAPTURE) && !opaque && (mask_q == '0));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (ENABLE) state_d = S_START;
      S_START:   state_d = (SPRITES_EN == '0) ? S_OUT : S_ISSUE;
      S_ISSUE:   state_d = (MEM_LAT > 1) ? S_WAIT : S_CAPTURE;
      S_WAIT:    if (wait_q == '0) state_d = S_CAPTURE;
      S_CAPTURE: state_d = (opaque || (mask_q == '0)) ? S_OUT : S_ISSUE;
      S_OUT:     if (PIX_READY) state_d = ENABLE ? S_START : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sprite walk: mask snapshot, current read index and read-latency counter.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mask_q <= '0;
      sel_q  <= '0;
      wait_q <= '0;
    end else begin
      if (state_q == S_START) begin
        mask_q <= SPRITES_EN;
      end else if (state_q == S_ISSUE) begin
        mask_q <= mask_q & (mask_q - N_SPRITES'(1));
        sel_q  <= low_idx;
        wait_q <= WAIT_INIT;
      end else if ((state_q == S_WAIT) && (wait_q != '0)) begin
        wait_q <= wait_q - CNT_W'(1);
      end
    end
  end

  // Address only moves on an accepted pixel, so it survives ENABLE going low.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      addr_q <= '0;
    end else if (accept) begin
      addr_q <= last_pix ? '0 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rgb_q       <= '0;
      hit_sel_q   <= '0;
      hit_bg_q    <= 1'b0;
      frame_end_q <= 1'b0;
    end else if (load_hit) begin
      rgb_q       <= DATA_IN;
      hit_sel_q   <= sel_q;
      hit_bg_q    <= 1'b0;
      frame_end_q <= last_pix;
    end else if (load_bg) begin
      rgb_q       <= BG_COLOR;
      hit_sel_q   <= '0;
      hit_bg_q    <= 1'b1;
      frame_end_q <= last_pix;
    end
  end

  // During ISSUE the index comes straight from the mask; afterwards it is held in sel_q.
  assign MEM_RD    = (state_q == S_ISSUE);
  assign MEM_SEL   = MEM_RD ? low_idx : sel_q;
  assign MEM_ADDR  = addr_q;
  assign RGB       = rgb_q;
  assign RGB_VALID = (state_q == S_OUT);
  assign HIT_SEL   = hit_sel_q;
  assign HIT_BG    = hit_bg_q;
  assign FRAME_END = frame_end_q;
  assign BUSY      = (state_q != S_IDLE);

endmodule

// File: doc/sprite_pixel_mixer.md
Name: sprite_pixel_mixer

Overview:
- Parametrised successor to the fixed 8-sprite pixel loader.
- Walks the frame pixel by pixel. For each pixel it reads the enabled sprite memories through one shared, externally muxed read port, in priority order.
- Outputs the first non-transparent colour, or a background colour when no sprite is opaque, to the downstream video stage through a valid/ready handshake.
- Adds over the previous generation: configurable sprite count, address width, memory latency and transparency key; early termination; downstream back-pressure.

Parameters:
N_SPRITES, 8, number of sprite memories, 1..16
SEL_W, $clog2(N_SPRITES) (min 1), width of MEM_SEL
ADDR_W, 16, pixel address width
PIXELS, 2**ADDR_W, pixels per frame; address wraps at PIXELS-1
DATA_W, 24, RGB word width
MEM_LAT, 1, read latency in cycles from the MEM_RD cycle to valid DATA_IN, >=1
TRANSPARENT, 24'hFF00FF, colour key treated as transparent
BG_COLOR, 24'h000000, colour output when no opaque sprite

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET_N  in  1  asynchronous active-low reset
ENABLE  in  1  run; when low, the block idles after finishing the current pixel
SPRITES_EN  in  N_SPRITES  per-sprite enable, bit 0 = highest priority
DATA_IN  in  DATA_W  read data from the memory selected by MEM_SEL
MEM_RD  out  1  read strobe, one cycle per read
MEM_ADDR  out  ADDR_W  current pixel address
MEM_SEL  out  SEL_W  sprite index being read
PIX_READY  in  1  downstream accepts the pixel
RGB  out  DATA_W  pixel colour
RGB_VALID  out  1  RGB is valid
HIT_SEL  out  SEL_W  index of the sprite that supplied RGB; 0 when background
HIT_BG  out  1  RGB is BG_COLOR
FRAME_END  out  1  high with RGB_VALID when MEM_ADDR==PIXELS-1
BUSY  out  1  state != IDLE

Behaviour:
- Reset (async, RESET_N=0) values:
  - MEM_RD, RGB_VALID, FRAME_END, BUSY, HIT_BG = 0.
  - MEM_ADDR, MEM_SEL, RGB, HIT_SEL = 0.
  - State = IDLE.
  - Applies immediately, including mid-read or mid-handshake.
- States and transitions:
  - IDLE: go to START when ENABLE=1.
  - START (1 cycle):
    - Snapshot SPRITES_EN into a pending mask. SPRITES_EN changes after START do not affect the current pixel.
    - Mask==0 -> OUT with BG_COLOR, HIT_BG=1, HIT_SEL=0, no reads.
    - Otherwise -> ISSUE.
  - ISSUE (1 cycle):
    - MEM_SEL = index of the lowest set bit of the pending mask; MEM_RD=1.
    - MEM_ADDR is stable for the whole pixel.
    - That bit is cleared from the mask.
    - Go to WAIT if MEM_LAT>1, else CAPTURE.
  - WAIT: MEM_LAT-1 cycles. MEM_SEL and MEM_ADDR are held; MEM_RD=0.
  - CAPTURE (1 cycle): sample DATA_IN.
    - DATA_IN != TRANSPARENT -> OUT with RGB=DATA_IN, HIT_SEL=MEM_SEL, HIT_BG=0. Early termination: remaining enabled sprites are not read.
    - Transparent and mask != 0 -> ISSUE.
    - Transparent and mask == 0 -> OUT with BG_COLOR, HIT_BG=1.
  - OUT:
    - RGB_VALID=1. RGB, HIT_SEL, HIT_BG, FRAME_END are registered and held stable until accepted.
    - On PIX_READY=1: pixel accepted. MEM_ADDR increments, wrapping PIXELS-1 -> 0.
    - Next state is START if ENABLE=1, else IDLE.
    - RGB_VALID drops in the following cycle, or stays low for START.
- Latency for MEM_LAT=1 with PIX_READY held high:
  - Each pixel costs 2 + 2*k cycles, where k = sprites read.
  - RGB_VALID rises 2*k+1 cycles after START (k=0 -> the cycle after START).
- ENABLE=0 mid-pixel: the current pixel completes, including the handshake; the block then enters IDLE with MEM_ADDR pointing to the next pixel.
- ENABLE=1 again resumes from the held MEM_ADDR. Only reset clears the address.
- Width rules:
  - Address arithmetic is modulo PIXELS (compare-and-clear, not a natural overflow, when PIXELS is not a power of 2).
  - SPRITES_EN bits >= N_SPRITES do not exist.
  - RGB is compared against TRANSPARENT over all DATA_W bits.

Test Plan:
1. Reset: assert RESET_N=0 mid-read (state WAIT, MEM_LAT=3) -> all outputs 0 in the same cycle. After release with ENABLE=0, the block stays IDLE with BUSY=0.
2. SPRITES_EN=0, ENABLE=1, PIX_READY=1 -> RGB_VALID every 2nd cycle, RGB=24'h000000, HIT_BG=1, MEM_RD never asserted, MEM_ADDR 0,1,2...
3. SPRITES_EN=8'b00000100, memory returns 24'h123456 -> exactly one MEM_RD with MEM_SEL=2; RGB=24'h123456, HIT_SEL=2, RGB_VALID 3 cycles after START.
4. SPRITES_EN=8'b00001011, sprite0 returns FF00FF, sprite1 returns AABBCC -> reads MEM_SEL=0 then 1 only (sprite 3 never read); RGB=AABBCC, HIT_SEL=1.
5. SPRITES_EN=8'hFF, all memories return FF00FF -> 8 reads, MEM_SEL 0..7 in order; RGB=BG_COLOR, HIT_BG=1. Changing SPRITES_EN to 0 during the reads does not shorten the sequence.
6. PIXELS=4 override, PIX_READY held low 5 cycles in OUT -> RGB/RGB_VALID stable and MEM_ADDR unchanged. Later, FRAME_END=1 only on addr 3, and the next pixel uses MEM_ADDR=0.
